// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: oversamples the camera's RGB444 byte stream in the
// system clock domain, decimates it 2:1 in both axes and issues one
// frame-buffer write per kept pixel at address row_out*DST_COLS + col_out.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cfg_done          camera register setup finished; capture is enabled only while high
//   ov7670_pclk       camera pixel clock (asynchronous, oversampled)
//   ov7670_vsync      camera vsync, high during vertical blanking
//   ov7670_href       camera href, high while line bytes are valid
//   ov7670_d          camera data byte
//   fb_we             frame-buffer write strobe (1 clk)
//   fb_addr           frame-buffer write address
//   fb_data           pixel {R[3:0],G[3:0],B[3:0]}
//   frame_done        1-clk pulse at the end of each captured frame
//   frame_err         1-clk pulse with frame_done when the kept-line count is wrong
//   capturing         high while a frame is being captured
module ov7670_capture #(
  parameter int SRC_COLS = 160,
  parameter int SRC_ROWS = 120,
  parameter int DST_COLS = 80,
  parameter int DST_ROWS = 60,
  parameter int AW       = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_done,
  input  logic          ov7670_pclk,
  input  logic          ov7670_vsync,
  input  logic          ov7670_href,
  input  logic [7:0]    ov7670_d,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [11:0]   fb_data,
  output logic          frame_done,
  output logic          frame_err,
  output logic          capturing
);

  localparam int CW = $clog2(SRC_COLS + 1);
  localparam int RW = $clog2(SRC_ROWS + 1);
  localparam int KW = $clog2(DST_ROWS + 1);

  localparam logic [CW-1:0] COL_LIM   = CW'(SRC_COLS);
  localparam logic [RW-1:0] ROW_LIM   = RW'(SRC_ROWS);
  localparam logic [KW-1:0] KEPT_TGT  = KW'(DST_ROWS);
  localparam logic [AW-1:0] LINE_STEP = AW'(DST_COLS);

  typedef enum logic [1:0] {WAIT_CFG, WAIT_VSYNC, CAPTURE} state_t;

  state_t state, state_nxt;

  logic pclk_s1, pclk_s2, pclk_s3;
  logic vsync_s1, vsync_s2, vsync_s3;
  logic href_s1, href_s2, href_s3;
  logic [7:0] d_s1, d_s2;

  logic pclk_rise, href_fall, vsync_rise, vsync_fall;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          phase;
  logic [3:0]    r_nib;
  logic [AW-1:0] line_base;
  logic [KW-1:0] kept;

  logic          start_p0, frame_end_p0;
  logic          line_end_p0, byte_en_p0, row_ok_p0, pix_keep_p0;
  logic [KW-1:0] kept_upd_p0;

  logic          vld_p1;
  logic [AW-1:0] addr_p1;
  logic [11:0]   data_p1;
  logic          done_p1, err_p1;

  // Counters stop at their limit so oversized lines or frames can never
  // wrap back into valid addresses.
  function automatic logic [CW-1:0] col_sat_inc(input logic [CW-1:0] v);
    return (v == COL_LIM) ? v : v + CW'(1);
  endfunction

  function automatic logic [RW-1:0] row_sat_inc(input logic [RW-1:0] v);
    return (v == ROW_LIM) ? v : v + RW'(1);
  endfunction

  // Input synchronisers; the third flop feeds edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3  <= 1'b0;
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_s3 <= 1'b0;
      href_s1  <= 1'b0; href_s2  <= 1'b0; href_s3  <= 1'b0;
      d_s1     <= 8'd0; d_s2     <= 8'd0;
    end else begin
      pclk_s1  <= ov7670_pclk;  pclk_s2  <= pclk_s1;  pclk_s3  <= pclk_s2;
      vsync_s1 <= ov7670_vsync; vsync_s2 <= vsync_s1; vsync_s3 <= vsync_s2;
      href_s1  <= ov7670_href;  href_s2  <= href_s1;  href_s3  <= href_s2;
      d_s1     <= ov7670_d;     d_s2     <= d_s1;
    end
  end

  assign pclk_rise  = pclk_s2 & ~pclk_s3;
  assign href_fall  = href_s3 & ~href_s2;
  assign vsync_rise = vsync_s2 & ~vsync_s3;
  assign vsync_fall = vsync_s3 & ~vsync_s2;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_CFG;
    else     state <= state_nxt;
  end

  // Losing cfg_done aborts silently from any state, ahead of frame end.
  always_comb begin
    state_nxt    = state;
    start_p0     = 1'b0;
    frame_end_p0 = 1'b0;
    case (state)
      WAIT_CFG: begin
        if (cfg_done) state_nxt = WAIT_VSYNC;
      end
      WAIT_VSYNC: begin
        if (!cfg_done) begin
          state_nxt = WAIT_CFG;
        end else if (vsync_fall) begin
          state_nxt = CAPTURE;
          start_p0  = 1'b1;
        end
      end
      CAPTURE: begin
        if (!cfg_done) begin
          state_nxt = WAIT_CFG;
        end else if (vsync_rise) begin
          state_nxt    = WAIT_VSYNC;
          frame_end_p0 = 1'b1;
        end
      end
      default: state_nxt = WAIT_CFG;
    endcase
  end

  // Stage 0: decode the synchronised strobes for the current capture state.
  always_comb begin
    line_end_p0 = (state == CAPTURE) && cfg_done && href_fall;
    byte_en_p0  = (state == CAPTURE) && cfg_done && pclk_rise && href_s2;
    row_ok_p0   = ~row[0] && (row < ROW_LIM);
    pix_keep_p0 = byte_en_p0 && phase && ~col[0] && (col < COL_LIM) && row_ok_p0;
    // The line ending in this cycle is counted before any same-cycle frame check.
    kept_upd_p0 = (line_end_p0 && row_ok_p0) ? kept + KW'(1) : kept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      phase     <= 1'b0;
      r_nib     <= 4'd0;
      line_base <= '0;
      kept      <= '0;
    end else if (start_p0) begin
      col       <= '0;
      row       <= '0;
      phase     <= 1'b0;
      line_base <= '0;
      kept      <= '0;
    end else if (line_end_p0) begin
      // A dangling first byte of an incomplete pixel is dropped here.
      col   <= '0;
      phase <= 1'b0;
      if (row_ok_p0) line_base <= line_base + LINE_STEP;
      kept  <= kept_upd_p0;
      row   <= row_sat_inc(row);
    end else if (byte_en_p0) begin
      if (!phase) begin
        r_nib <= d_s2[3:0];
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        col   <= col_sat_inc(col);
      end
    end
  end

  // Stage 1: registered write request and frame status.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= 12'd0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1  <= pix_keep_p0;
      if (pix_keep_p0) begin
        addr_p1 <= line_base + AW'(col >> 1);
        data_p1 <= {r_nib, d_s2};
      end
      done_p1 <= frame_end_p0;
      err_p1  <= frame_end_p0 && (kept_upd_p0 != KEPT_TGT);
    end
  end

  assign fb_we      = vld_p1;
  assign fb_addr    = addr_p1;
  assign fb_data    = data_p1;
  assign frame_done = done_p1;
  assign frame_err  = err_p1;
  assign capturing  = (state == CAPTURE);

endmodule

// File: tb/tb_ov7670_capture.sv
module tb_ov7670_capture;

  localparam int SRC_COLS = 24;
  localparam int SRC_ROWS = 16;
  localparam int DST_COLS = 12;
  localparam int DST_ROWS = 8;
  localparam int AW       = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_done;
  logic          pclk;
  logic          vsync;
  logic          href;
  logic [7:0]    d;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [11:0]   fb_data;
  logic          frame_done;
  logic          frame_err;
  logic          capturing;

  ov7670_capture #(
    .SRC_COLS(SRC_COLS), .SRC_ROWS(SRC_ROWS),
    .DST_COLS(DST_COLS), .DST_ROWS(DST_ROWS), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_done(cfg_done),
    .ov7670_pclk(pclk), .ov7670_vsync(vsync), .ov7670_href(href), .ov7670_d(d),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .frame_err(frame_err), .capturing(capturing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation side: record every write and status pulse.
  int obs_addr [0:4095];
  int obs_data [0:4095];
  int obs_cyc  [0:4095];
  int obs_n    = 0;
  int wmem     [0:127];
  int done_n   = 0;
  int derr_n   = 0;
  int orphan_n = 0;
  int cap_n    = 0;

  always @(negedge clk) begin
    if (fb_we) begin
      if (obs_n < 4096) begin
        obs_addr[obs_n] <= int'(fb_addr);
        obs_data[obs_n] <= int'(fb_data);
        obs_cyc[obs_n]  <= cyc;
      end
      obs_n <= obs_n + 1;
      wmem[fb_addr] <= int'(fb_data);
    end
    if (frame_done) done_n <= done_n + 1;
    if (frame_done && frame_err) derr_n <= derr_n + 1;
    if (frame_err && !frame_done) orphan_n <= orphan_n + 1;
    if (capturing) cap_n <= cap_n + 1;
  end

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  typedef struct {
    int lines;
    int pix;
    int odd_line;
    int coinc;
    int exp_writes;
    int exp_first;
    int exp_last;
    int exp_done;
    int exp_err;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   rd = 0;
  bit   expect_on = 1'b0;
  int   done0, derr0, cap0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cam_byte(input logic [7:0] b, input logic hv, input logic vs, output int dc);
    @(negedge clk);
    pclk = 1'b0; href = hv; vsync = vs; d = b;
    @(negedge clk);
    @(negedge clk);
    pclk = 1'b1;
    dc = cyc;
    @(negedge clk);
  endtask

  task automatic send_line(input int r, input int npix, input bit extra, input bit vs_end);
    int   dc;
    exp_t e;
    logic [7:0] rb;
    rb = {4'h0, r[3:0]};
    for (int c = 0; c < npix; c++) begin
      cam_byte(rb, 1'b1, 1'b0, dc);
      cam_byte(c[7:0], 1'b1, 1'b0, dc);
      if (expect_on && r < SRC_ROWS && c < SRC_COLS && (r % 2) == 0 && (c % 2) == 0) begin
        e.addr = (r / 2) * DST_COLS + c / 2;
        e.data = (r % 16) * 256 + c;
        e.cyc  = dc + 3;
        exp_q.push_back(e);
      end
    end
    if (extra) cam_byte(rb, 1'b1, 1'b0, dc);
    for (int k = 0; k < 4; k++) cam_byte(8'h00, 1'b0, vs_end, dc);
  endtask

  task automatic frame_start();
    int dc;
    for (int k = 0; k < 3; k++) cam_byte(8'h00, 1'b0, 1'b1, dc);
    for (int k = 0; k < 3; k++) cam_byte(8'h00, 1'b0, 1'b0, dc);
  endtask

  task automatic frame_end();
    int dc;
    for (int k = 0; k < 4; k++) cam_byte(8'h00, 1'b0, 1'b1, dc);
  endtask

  task automatic snap();
    done0 = done_n;
    derr0 = derr_n;
    cap0  = cap_n;
  endtask

  task automatic check_writes(input string tag, input int exp_n, input int exp_first, input int exp_last);
    int n;
    n = obs_n - rd;
    chk({tag, " write count"}, n, exp_n);
    chk({tag, " model count"}, n, exp_q.size());
    if (n > 0) begin
      chk({tag, " first addr"}, obs_addr[rd], exp_first);
      chk({tag, " last addr"}, obs_addr[rd + n - 1], exp_last);
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, " addr"}, obs_addr[rd + i], exp_q[i].addr);
      chk({tag, " data"}, obs_data[rd + i], exp_q[i].data);
      chk({tag, " latency"}, obs_cyc[rd + i], exp_q[i].cyc);
    end
    rd = obs_n;
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " fb_we"}, int'(fb_we), 0);
    chk({tag, " fb_addr"}, int'(fb_addr), 0);
    chk({tag, " fb_data"}, int'(fb_data), 0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
    chk({tag, " frame_err"}, int'(frame_err), 0);
    chk({tag, " capturing"}, int'(capturing), 0);
  endtask

  task automatic full_frame(input string tag);
    snap();
    frame_start();
    for (int r = 0; r < SRC_ROWS; r++) send_line(r, SRC_COLS, 1'b0, 1'b0);
    frame_end();
    check_writes(tag, DST_COLS * DST_ROWS, 0, DST_COLS * DST_ROWS - 1);
    chk({tag, " done"}, done_n - done0, 1);
    chk({tag, " err"}, derr_n - derr0, 0);
  endtask

  initial begin
    //             lines pix odd coinc writes first last done err
    vecs[0] = '{16, 24, -1, 0, 96, 0, 95, 1, 0};  // full frame
    vecs[1] = '{10, 24, -1, 0, 60, 0, 59, 1, 1};  // short frame
    vecs[2] = '{16, 29,  3, 0, 96, 0, 95, 1, 0};  // long lines, one odd-byte line
    vecs[3] = '{15, 24, -1, 1, 96, 0, 95, 1, 0};  // href_fall with vsync_rise
    vecs[4] = '{18, 24, -1, 0, 96, 0, 95, 1, 0};  // extra lines beyond SRC_ROWS

    rst = 1'b1; cfg_done = 1'b0; pclk = 1'b0; vsync = 1'b1; href = 1'b0; d = 8'h00;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // No configuration: camera runs but nothing is captured.
    expect_on = 1'b0;
    snap();
    frame_start();
    for (int r = 0; r < 6; r++) send_line(r, SRC_COLS, 1'b0, 1'b0);
    frame_end();
    check_writes("nocfg", 0, 0, 0);
    chk("nocfg done", done_n - done0, 0);
    chk("nocfg capturing", cap_n - cap0, 0);

    cfg_done = 1'b1;
    expect_on = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      snap();
      frame_start();
      for (int r = 0; r < vecs[v].lines; r++) begin
        if (r == vecs[v].odd_line)
          send_line(r, SRC_COLS, 1'b1, 1'b0);
        else
          send_line(r, vecs[v].pix, 1'b0, (vecs[v].coinc != 0) && (r == vecs[v].lines - 1));
      end
      frame_end();
      check_writes($sformatf("vec%0d", v), vecs[v].exp_writes, vecs[v].exp_first, vecs[v].exp_last);
      chk($sformatf("vec%0d done", v), done_n - done0, vecs[v].exp_done);
      chk($sformatf("vec%0d err", v), derr_n - derr0, vecs[v].exp_err);
      chk($sformatf("vec%0d capturing", v), int'(cap_n - cap0 > 0), 1);
      if (v == 0) chk("row2 col2 at addr 13", wmem[DST_COLS + 1], 2 * 256 + 2);
    end

    // Config dropped mid-frame: partial frame silently abandoned.
    snap();
    frame_start();
    for (int r = 0; r < 5; r++) send_line(r, SRC_COLS, 1'b0, 1'b0);
    check_writes("predrop", 36, 0, 35);
    cfg_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("cfgdrop capturing", int'(capturing), 0);
    cfg_done = 1'b1;
    expect_on = 1'b0;
    for (int r = 5; r < SRC_ROWS; r++) send_line(r, SRC_COLS, 1'b0, 1'b0);
    frame_end();
    check_writes("dropped", 0, 0, 0);
    chk("cfgdrop done", done_n - done0, 0);
    expect_on = 1'b1;
    full_frame("afterdrop");

    // Reset pulsed in the middle of a frame.
    snap();
    frame_start();
    for (int r = 0; r < 6; r++) send_line(r, SRC_COLS, 1'b0, 1'b0);
    check_writes("prereset", 36, 0, 35);
    chk("prereset addr held", int'(fb_addr), 35);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b0;
    expect_on = 1'b0;
    for (int r = 6; r < SRC_ROWS; r++) send_line(r, SRC_COLS, 1'b0, 1'b0);
    frame_end();
    check_writes("postreset", 0, 0, 0);
    chk("postreset done", done_n - done0, 0);
    expect_on = 1'b1;
    full_frame("afterreset");

    chk("err without done", orphan_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Downstream neighbour of the OV7670 SCCB control stage: captures the RGB444 pixel stream the configured camera produces and turns it into frame-buffer write requests.
- Camera runs QQVGA 160x120. The block decimates by 2 in both axes to 80x60 and writes one 12-bit RGB444 word per kept pixel, at a linear address, into a dual-port frame buffer read by the VGA/processing side.
- All camera inputs are oversampled in the single FPGA clock domain. clk must be at least 4x ov7670_pclk.

Parameters:
- SRC_COLS, 160, source pixels per line (2 bytes each)
- SRC_ROWS, 120, source lines per frame
- DST_COLS, 80, output pixels per line (SRC_COLS/2)
- DST_ROWS, 60, output lines per frame (SRC_ROWS/2)
- AW, 13, frame-buffer address width; must satisfy 2^AW >= DST_COLS*DST_ROWS

Ports:
- clk  in  1  FPGA clock
- rst  in  1  reset, synchronous, active-high
- cfg_done  in  1  '1' once the camera register sequence is complete (done from the SCCB control stage)
- ov7670_pclk  in  1  camera pixel clock (asynchronous)
- ov7670_vsync  in  1  camera vsync; high during vertical blanking
- ov7670_href  in  1  camera href; high while line bytes are valid
- ov7670_d  in  8  camera data byte
- fb_we  out  1  frame-buffer write enable, 1-cycle pulse
- fb_addr  out  AW  write address = row_out*DST_COLS + col_out
- fb_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  1-cycle pulse at end of each captured frame
- frame_err  out  1  1-cycle pulse, coincident with frame_done, when kept-line count != DST_ROWS
- capturing  out  1  '1' while in state CAPTURE

Behaviour:
- Reset: all outputs 0; state WAIT_CFG; all counters and synchroniser flops 0.
- Input sync:
  - pclk, vsync, href and d each pass through 2 flops (s1, s2), plus a third flop on pclk, vsync and href for edge detection.
  - pclk_rise = pclk_s2 & ~pclk_s3.
  - href_fall and vsync_rise/vsync_fall are formed the same way.
  - Data is sampled from d_s2 in the pclk_rise cycle.
- FSM:
  - WAIT_CFG -> WAIT_VSYNC when cfg_done=1.
  - WAIT_VSYNC -> CAPTURE on vsync_fall. On entry: row=0, col=0, byte phase=0, line base=0.
  - CAPTURE -> WAIT_VSYNC on vsync_rise. In that cycle frame_done=1 and frame_err = (kept lines != DST_ROWS).
  - Any state -> WAIT_CFG when cfg_done=0. No frame_done in that case.
- Byte assembly (CAPTURE, pclk_rise & href_s2):
  - phase 0 stores d[3:0] as R.
  - phase 1 forms pixel {R, d[7:0]}, increments col, and toggles phase back.
- Decimation: a pixel is written only if col[0]==0 and row[0]==0, and col < SRC_COLS and row < SRC_ROWS. Excess pixels or lines are dropped silently and never wrap the address.
- Write timing:
  - fb_we, fb_addr and fb_data are registered.
  - fb_we is asserted 1 clk after the pclk_rise cycle that completes the pixel.
  - fb_addr = line_base + col/2.
- Line end (href_fall in CAPTURE):
  - col=0, phase=0.
  - If the ending line was kept (row[0]==0), line_base += DST_COLS and the kept-line counter increments.
  - row increments, saturating at SRC_ROWS.
- Odd byte count at href_fall: the dangling phase-0 byte is discarded.
- vsync_rise and href_fall in the same cycle: line-end bookkeeping is applied first, then the frame-end check.
- Reset mid-frame: everything returns to reset values in the next cycle; capture restarts only after cfg_done and a fresh vsync_fall.

Test Plan:
1. Full frame: rst, cfg_done=1, camera model (pclk=clk/4) sends one 160x120 frame with pixel bytes {0x0R, GB} = {row[3:0], col[7:0]} -> exactly 4800 fb_we pulses, addresses 0..4799 each once. The first word is addr 0 with data 0x000. Addr 81 holds the pixel from source row 2, col 2. Then one frame_done, frame_err=0.
2. No config: cfg_done=0 while a frame is sent -> no fb_we, no frame_done, capturing=0.
3. Mid-frame config drop: cfg_done deasserted mid-frame, reasserted, then a full frame -> no frame_done for the partial frame; the next frame writes addresses from 0.
4. Short frame: only 100 lines -> 50 kept lines (last addr 3999), then frame_done with frame_err=1.
5. Long/malformed lines: lines of 170 pixels and one of 161 bytes -> no write beyond col_out 79 per line; the dangling byte is dropped; the next line starts at line_base+80.
6. Reset during frame: rst pulsed at line 30 -> all outputs 0 the next cycle; nothing is written until the next vsync_fall, after which addr restarts at 0.
